// File: rtl/gaussian_conv.sv
// Separable 5x5 Gaussian blur ([1 4 6 4 1] outer product), 3-stage stall-free pipeline
// with output column/row tracking. Define BLUR_ROUND_EN for round-half-up normalisation.
module gaussian_conv #(
    parameter int IMG_COLS = 640,
    parameter int IMG_ROWS = 480
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [199:0] window_in,
    input  logic         in_valid,
    input  logic         sof,
    output logic [7:0]   pixel_out,
    output logic         out_valid,
    output logic [9:0]   out_col,
    output logic [8:0]   out_row,
    output logic         line_done,
    output logic         frame_done
);

    localparam logic [9:0] LAST_COL = 10'(IMG_COLS - 1);
    localparam logic [8:0] LAST_ROW = 9'(IMG_ROWS - 1);
`ifdef BLUR_ROUND_EN
    localparam logic [16:0] ROUND_BIAS = 17'd128;
`else
    localparam logic [16:0] ROUND_BIAS = 17'd0;
`endif

    function automatic logic [11:0] tap_h(input logic [39:0] row);
        logic [11:0] p [5];
        for (int i = 0; i < 5; i++) p[i] = {4'd0, row[8*i +: 8]};
        return p[0] + (p[1] << 2) + (p[2] << 2) + (p[2] << 1) + (p[3] << 2) + p[4];
    endfunction

    function automatic logic [15:0] tap_v(input logic [11:0] h [5]);
        logic [15:0] p [5];
        for (int i = 0; i < 5; i++) p[i] = {4'd0, h[i]};
        return p[0] + (p[1] << 2) + (p[2] << 2) + (p[2] << 1) + (p[3] << 2) + p[4];
    endfunction

    // The clamp cannot trigger for 8-bit inputs; it guards against a future kernel change.
    function automatic logic [7:0] norm_sat(input logic [15:0] v);
        logic [16:0] s;
        s = {1'b0, v} + ROUND_BIAS;
        return s[16] ? 8'hFF : s[15:8];
    endfunction

    logic [11:0] h_p1_d [5];
    logic [11:0] h_p1_q [5];
    logic        vld_p1_d, vld_p1_q;
    logic [15:0] v_p2_d, v_p2_q;
    logic        vld_p2_d, vld_p2_q;
    logic [7:0]  pix_p3_d, pix_p3_q;
    logic        vld_p3_d, vld_p3_q;
    logic [9:0]  col_d, col_q;
    logic [8:0]  row_d, row_q;

    always_comb begin
        // stage 1: horizontal taps
        for (int r = 0; r < 5; r++) h_p1_d[r] = tap_h(window_in[40*r +: 40]);
        vld_p1_d = in_valid;
        // stage 2: vertical taps
        v_p2_d   = tap_v(h_p1_q);
        vld_p2_d = vld_p1_q;
        // stage 3: normalise
        pix_p3_d = norm_sat(v_p2_q);
        vld_p3_d = vld_p2_q;

        col_d = col_q;
        row_d = row_q;
        if (sof) begin
            col_d = '0;
            row_d = '0;
        end else if (vld_p3_q) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? 9'd0 : row_q + 9'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
        end
    end

    // Datapath registers carry don't-care values when their valid bit is low.
    always_ff @(posedge clk) begin
        h_p1_q <= h_p1_d;
        v_p2_q <= v_p2_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            pix_p3_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            pix_p3_q <= pix_p3_d;
            col_q    <= col_d;
            row_q    <= row_d;
        end
    end

    assign pixel_out  = pix_p3_q;
    assign out_valid  = vld_p3_q;
    assign out_col    = col_q;
    assign out_row    = row_q;
    assign line_done  = vld_p3_q && (col_q == LAST_COL);
    assign frame_done = line_done && (row_q == LAST_ROW);

endmodule
